// File: rtl/serial_rx_sequencer_if.sv
// Byte handoff bundle between the serial receive sequencer (master) and the
// word consumer (slave): captured word, valid flag and consumer ready.
interface serial_rx_sequencer_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] BYTE_DATA;
  logic              BYTE_VALID;
  logic              BYTE_READY;

  modport master (
    output BYTE_DATA,
    output BYTE_VALID,
    input  BYTE_READY
  );

  modport slave (
    input  BYTE_DATA,
    input  BYTE_VALID,
    output BYTE_READY
  );
endinterface

// File: rtl/serial_rx_sequencer.sv
// LSB-first serial frame receiver: start detect, mid-bit sampling, stop check
// and valid/ready word delivery. Optional even parity check under `PARITY_CHECK_EN.
module serial_rx_sequencer #(
  parameter int DATA_W     = 8,
  parameter int BIT_PERIOD = 4
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  SER_IN,
  serial_rx_sequencer_if.master byte_if,
  output logic                  SHIFT_EN,
  output logic                  BUSY,
  output logic                  FRAME_ERR,
`ifdef PARITY_CHECK_EN
  output logic                  PARITY_ERR,
`endif
  output logic                  OVERRUN
);

  localparam int CYC_W  = $clog2(BIT_PERIOD);
  localparam int BITS_W = (DATA_W > 1) ? $clog2(DATA_W + 1) : 1;

`ifdef PARITY_CHECK_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t              state_q, state_d;
  logic                ser_meta_q, ser_meta_d;
  logic                ser_s_q, ser_s_d;
  logic [CYC_W-1:0]    cyc_q, cyc_d;
  logic [BITS_W-1:0]   bits_q, bits_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                frame_err_q, frame_err_d;
  logic                overrun_q, overrun_d;
`ifdef PARITY_CHECK_EN
  logic                parity_bad_q, parity_bad_d;
  logic                parity_err_q, parity_err_d;
`endif

  logic mid_start;
  logic bit_end;
  logic last_bit;

  assign mid_start = (cyc_q == CYC_W'(BIT_PERIOD / 2 - 1));
  assign bit_end   = (cyc_q == CYC_W'(BIT_PERIOD - 1));
  assign last_bit  = (bits_q == BITS_W'(DATA_W - 1));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (!ser_s_q) state_d = START;
      START: if (mid_start) state_d = ser_s_q ? IDLE : DATA;
`ifdef PARITY_CHECK_EN
      DATA:   if (bit_end && last_bit) state_d = PARITY;
      PARITY: if (bit_end) state_d = STOP;
`else
      DATA:  if (bit_end && last_bit) state_d = STOP;
`endif
      STOP:  if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and strobes; the stop-bit sample decides deliver / drop / overrun.
  always_comb begin
    ser_meta_d  = SER_IN;
    ser_s_d     = ser_meta_q;
    cyc_d       = cyc_q;
    bits_d      = bits_q;
    shreg_d     = shreg_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
`ifdef PARITY_CHECK_EN
    parity_bad_d = parity_bad_q;
    parity_err_d = 1'b0;
`endif
    SHIFT_EN    = 1'b0;
    BUSY        = (state_q != IDLE);

    if (valid_q && byte_if.BYTE_READY) valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        cyc_d  = '0;
        bits_d = '0;
      end
      START: begin
        bits_d = '0;
        cyc_d  = mid_start ? '0 : cyc_q + CYC_W'(1);
      end
      DATA: begin
        if (bit_end) begin
          SHIFT_EN            = 1'b1;
          shreg_d             = shreg_q >> 1;
          shreg_d[DATA_W-1]   = ser_s_q;
          bits_d              = bits_q + BITS_W'(1);
          cyc_d               = '0;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
`ifdef PARITY_CHECK_EN
      PARITY: begin
        if (bit_end) begin
          parity_bad_d = (^shreg_q) ^ ser_s_q;
          cyc_d        = '0;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          cyc_d = '0;
          if (!ser_s_q) begin
            frame_err_d = 1'b1;
`ifdef PARITY_CHECK_EN
          end else if (parity_bad_q) begin
            parity_err_d = 1'b1;
`endif
          end else if (!valid_q || byte_if.BYTE_READY) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      default: begin
        cyc_d  = '0;
        bits_d = '0;
      end
    endcase
  end

  // Synchroniser resets to the idle-high line level so reset never fakes a start.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ser_meta_q  <= 1'b1;
      ser_s_q     <= 1'b1;
      cyc_q       <= '0;
      bits_q      <= '0;
      shreg_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef PARITY_CHECK_EN
      parity_bad_q <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      ser_meta_q  <= ser_meta_d;
      ser_s_q     <= ser_s_d;
      cyc_q       <= cyc_d;
      bits_q      <= bits_d;
      shreg_q     <= shreg_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef PARITY_CHECK_EN
      parity_bad_q <= parity_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign byte_if.BYTE_DATA  = data_q;
  assign byte_if.BYTE_VALID = valid_q;
  assign FRAME_ERR          = frame_err_q;
  assign OVERRUN            = overrun_q;
`ifdef PARITY_CHECK_EN
  assign PARITY_ERR         = parity_err_q;
`endif

endmodule
